dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

Store queue placed directly upstream of the data memory (DM) in the MEM stage. It accepts word, half and byte stores from the pipeline and keeps them in a small FIFO. Queued stores drain into the single-ported DM whenever no load needs the port. Loads that hit a pending store's word are stalled until that store has drained.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `clk` in 1: single clock; everything updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `st_valid` in 1: MEM-stage store request this cycle.
- `st_addr` in 32: store byte address.
- `st_data` in 32: store data, right-aligned; low 16/8 bits used for HALF/BYTE.
- `st_width` in 2: 00 WORD, 01 HALF, 10 BYTE; 11 illegal.
- `st_pc` in 32: PC of the store, carried to DM for the write trace.
- `ld_valid` in 1: MEM-stage load request this cycle.
- `ld_addr` in 32: load byte address.
- `ld_width` in 2: load width, passed through to DM.
- `dm_we` out 1: DM write enable.
- `dm_width` out 2: DM access width.
- `dm_addr` out 32: DM address.
- `dm_wd` out 32: DM write data.
- `dm_pc` out 32: DM trace PC.
- `stall` out 1: freeze the pipeline at MEM and earlier.
- `empty` out 1: no entries valid.
- `count` out $clog2(DEPTH)+1: number of valid entries.

## Operation
- **Entry contents.** Each entry is {addr, data, width, pc}. Storage is a circular FIFO with head pointer, tail pointer and count.
- **Load hazard.** `ld_hazard` = `ld_valid` and some valid entry has `addr[11:2]` equal to `ld_addr[11:2]`. The compare is word-granular, which is conservative for sub-word accesses.
- **Port ownership.** The load owns the DM port when `ld_valid` and not `ld_hazard`. In that case:
  - `dm_we`=0, `dm_addr`=`ld_addr`, `dm_width`=`ld_width`;
  - `dm_wd` and `dm_pc` are don't-care, driven as 0.
- **Drain.** `drain` = not `empty` and not (`ld_valid` and not `ld_hazard`). While draining:
  - `dm_we`=1;
  - `dm_addr`, `dm_wd`, `dm_width`, `dm_pc` come from the head entry;
  - the head pops at the next edge.
- **Idle.** Otherwise all `dm_*` outputs are 0.
- **Push.**
  - `push` = `st_valid` and `st_width`≠11 and (`count`<`DEPTH` or `drain`).
  - A push writes the tail entry and advances the tail.
  - `st_width`=11: the request is dropped and does not stall.
- **Stall.** `stall` = `ld_hazard` or (`st_valid` and `count`==`DEPTH` and not `drain`).
- **Count update.** Push with pop: `count` unchanged. Push only: +1. Pop only: −1.
- **Pointer arithmetic.** Pointers are $clog2(DEPTH) bits wide and wrap modulo `DEPTH`.
- **Both requests in one cycle.** `st_valid` and `ld_valid` together is illegal upstream. If it happens, the load still takes port priority, and the push rule applies unchanged.

## Timing
- **Reset.** Pointers and `count` go to 0 and `empty`=1. Every `dm_*` output and `stall` is 0 in the cycle after reset. Any pending stores are discarded.
- **Combinational paths.** All `dm_*` outputs and `stall` are combinational from registered state plus the current `st_*`/`ld_*` inputs. No output is registered.
- **Store latency.** A store pushed at edge N is presented to DM during cycle N+1 at the earliest and committed by DM at edge N+1. Each queued entry ahead of it, and each cycle a load owns the port, adds one cycle.
- **Hazard clearing.** During a hazard stall the load yields the port, so draining continues. The stall clears in the cycle after the matching entry pops, at most `count` cycles.
- **Full and stalled.** A stalled store must be held stable by the pipeline and is accepted on the first cycle the push condition is true.
- **Full with drain.** At `count`==`DEPTH` with `drain`=1, a push is accepted in the same cycle and `stall`=0.

## Structure
- **Shared package / define file.** Holds the WORD/HALF/BYTE width codes (shared with DM) and the default `DEPTH`.
- **Sub-module `sb_fifo`.** Contains the entry storage, pointers, count, and the parallel word-address match vector.
- **Top level.** Holds the port mux, the push/drain/stall logic, and one `sb_fifo` instance.

## Test plan
- **Basic drain.** Reset, then SW 0x10←0x12345678 (pc 0x3000) with no loads. Expect cycle+1: `dm_we`=1, `dm_addr`=0x10, `dm_wd`=0x12345678, `dm_pc`=0x3000; `empty`=1 after that edge.
- **Fill while loads block drain.** Four stores (SB 0x1 ←0xAB, SH 0x6, SW 0x8, SW 0xC) while `ld_valid` to 0x100 blocks draining. Expect `count`=4. A fifth store, still with the load active: `stall`=1. Drop the load: entries drain in order with widths 10, 01, 00, 00, and the fifth store is accepted on the first drain cycle.
- **Load hazard.** SW 0x20←0xDEADBEEF pending, then LW 0x20. Expect `stall`=1 for exactly one cycle, `dm_we`=1 to 0x20, then `dm_addr`=0x20 with `dm_we`=0 and `stall`=0.
- **Sub-word match.** Pending SB 0x23 and LB 0x21 (same word). Expect a hazard stall. A load of 0x24 gives no stall.
- **Illegal width and reset mid-drain.** `st_width`=11 gives no push and `count` unchanged. Three entries pending, then assert `reset`: next cycle `count`=0, `dm_we`=0, `stall`=0.

Source files
------------

// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: DM access width codes,
// default queue depth and the queued-store entry layout.
package dm_store_buffer_pkg;

   // Width codes are shared with the data memory.
   typedef enum logic [1:0] {
      WIDTH_WORD    = 2'b00,
      WIDTH_HALF    = 2'b01,
      WIDTH_BYTE    = 2'b10,
      WIDTH_ILLEGAL = 2'b11
   } width_e;

   localparam int SB_DEPTH = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  width;
      logic [31:0] pc;
   } sb_entry_t;

endpackage

// File: rtl/dm_store_buffer_if.sv
// Pipeline <-> store buffer <-> data memory signal bundle.
import dm_store_buffer_pkg::*;

interface dm_store_buffer_if #(
   parameter int DEPTH = SB_DEPTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   // Handshake: st_valid/ld_valid are requests for this cycle. A store is
   // taken at the edge where stall is low (or it carries the illegal width
   // and is dropped); while stall is high the pipeline holds every st_*/ld_*
   // input stable and re-presents the same request next cycle.
   logic          st_valid;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic [1:0]    st_width;
   logic [31:0]   st_pc;
   logic          ld_valid;
   logic [31:0]   ld_addr;
   logic [1:0]    ld_width;

   logic          dm_we;
   logic [1:0]    dm_width;
   logic [31:0]   dm_addr;
   logic [31:0]   dm_wd;
   logic [31:0]   dm_pc;
   logic          stall;
   logic          empty;
   logic [CW-1:0] count;

   modport master (
      output st_valid, st_addr, st_data, st_width, st_pc,
      output ld_valid, ld_addr, ld_width,
      input  dm_we, dm_width, dm_addr, dm_wd, dm_pc,
      input  stall, empty, count
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_width, st_pc,
      input  ld_valid, ld_addr, ld_width,
      output dm_we, dm_width, dm_addr, dm_wd, dm_pc,
      output stall, empty, count
   );

endinterface

// File: rtl/dm_store_buffer_sb_fifo.sv
// Circular store queue with per-entry valid bits and a parallel
// word-address match against the current load address.
module sb_fifo
   import dm_store_buffer_pkg::*;
#(
   parameter int  DEPTH = SB_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  sb_entry_t        push_entry,
   input  logic             pop,
   input  logic [9:0]       match_word,
   output sb_entry_t        head_entry,
   output logic [DEPTH-1:0] match_vec,
   output logic [CW-1:0]    count,
   output logic             empty
);

   sb_entry_t        mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         // With the queue full, head == tail: the push set wins over the pop clear.
         if (pop) begin
            head        <= head + PW'(1);
            valid[head] <= 1'b0;
         end
         if (push) begin
            tail        <= tail + PW'(1);
            valid[tail] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= push_entry;
   end

   always_comb begin
      match_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = valid[i] && (mem[i].addr[11:2] == match_word);
      end
   end

   assign head_entry = mem[head];
   assign empty      = (count == '0);

endmodule

// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer: queues stores, drains them into the single-ported
// DM when no load owns the port, and stalls loads that hit a pending word.
module dm_store_buffer
   import dm_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input logic               clk,
   input logic               reset,
   dm_store_buffer_if.slave  sb
);

   localparam int CW = $clog2(DEPTH) + 1;

   sb_entry_t        push_entry;
   sb_entry_t        head_entry;
   logic [DEPTH-1:0] match_vec;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             ld_hazard;
   logic             load_owns;
   logic             drain;
   logic             st_legal;
   logic             push;

   assign full      = (count == CW'(DEPTH));
   assign ld_hazard = sb.ld_valid && (|match_vec);
   assign load_owns = sb.ld_valid && !ld_hazard;
   assign drain     = !empty && !load_owns;
   assign st_legal  = (sb.st_width != WIDTH_ILLEGAL);
   // A full queue still accepts a store in the same cycle the head drains.
   assign push      = sb.st_valid && st_legal && (!full || drain);
   // Illegal-width stores are dropped outright, so they never wait on space.
   assign sb.stall  = ld_hazard || (sb.st_valid && st_legal && full && !drain);

   assign push_entry = '{addr:  sb.st_addr,
                         data:  sb.st_data,
                         width: sb.st_width,
                         pc:    sb.st_pc};

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (drain),
      .match_word (sb.ld_addr[11:2]),
      .head_entry (head_entry),
      .match_vec  (match_vec),
      .count      (count),
      .empty      (empty)
   );

   always_comb begin
      sb.dm_we    = 1'b0;
      sb.dm_width = 2'b00;
      sb.dm_addr  = 32'h0;
      sb.dm_wd    = 32'h0;
      sb.dm_pc    = 32'h0;
      if (load_owns) begin
         sb.dm_addr  = sb.ld_addr;
         sb.dm_width = sb.ld_width;
      end else if (drain) begin
         sb.dm_we    = 1'b1;
         sb.dm_addr  = head_entry.addr;
         sb.dm_wd    = head_entry.data;
         sb.dm_width = head_entry.width;
         sb.dm_pc    = head_entry.pc;
      end
   end

   assign sb.count = count;
   assign sb.empty = empty;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: drain order, full/stall, load hazards,
// illegal width and reset while entries are pending.
module tb_dm_store_buffer;
   import dm_store_buffer_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   // {addr, data, pc, width} of stores expected on the DM write port, in order.
   logic [97:0] exp_q[$];

   dm_store_buffer_if #(.DEPTH(4)) bus ();

   dm_store_buffer #(.DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.st_valid = 1'b0;
      bus.st_addr  = 32'h0;
      bus.st_data  = 32'h0;
      bus.st_width = 2'b00;
      bus.st_pc    = 32'h0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = 32'h0;
      bus.ld_width = 2'b00;
   endtask

   task automatic drive_st(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] w, input logic [31:0] pc,
                           input bit expect_drain);
      bus.st_valid = 1'b1;
      bus.st_addr  = a;
      bus.st_data  = d;
      bus.st_width = w;
      bus.st_pc    = pc;
      if (expect_drain) exp_q.push_back({a, d, pc, w});
   endtask

   task automatic drive_ld(input logic [31:0] a, input logic [1:0] w);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_width = w;
   endtask

   task automatic check_drain(input string tag);
      logic [97:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: no expected store left in queue", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_we"},    32'(bus.dm_we),    32'h1);
         chk({tag, "_addr"},  bus.dm_addr,       e[97:66]);
         chk({tag, "_wd"},    bus.dm_wd,         e[65:34]);
         chk({tag, "_pc"},    bus.dm_pc,         e[33:2]);
         chk({tag, "_width"}, 32'(bus.dm_width), 32'(e[1:0]));
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_we",    32'(bus.dm_we), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_addr",  bus.dm_addr,    32'h0);

      // Basic drain: store appears on DM the cycle after it is pushed.
      drive_st(32'h10, 32'h12345678, WIDTH_WORD, 32'h3000, 1'b1);
      #1;
      chk("sw_stall", 32'(bus.stall), 32'd0);
      tick();
      idle_inputs();
      #1;
      check_drain("basic");
      tick();
      chk("basic_empty", 32'(bus.empty), 32'd1);
      chk("basic_idle_we", 32'(bus.dm_we), 32'd0);

      // Fill while a load to 0x100 owns the port.
      drive_ld(32'h100, WIDTH_WORD);
      drive_st(32'h1, 32'h000000AB, WIDTH_BYTE, 32'h3004, 1'b1);
      #1;
      chk("fill_ld_we",   32'(bus.dm_we), 32'd0);
      chk("fill_ld_addr", bus.dm_addr,    32'h100);
      tick();
      drive_st(32'h6, 32'h0000BEEF, WIDTH_HALF, 32'h3008, 1'b1);
      tick();
      drive_st(32'h8, 32'h11112222, WIDTH_WORD, 32'h300C, 1'b1);
      tick();
      drive_st(32'hC, 32'h33334444, WIDTH_WORD, 32'h3010, 1'b1);
      tick();
      chk("fill_count", 32'(bus.count), 32'd4);
      drive_st(32'h40, 32'h00000055, WIDTH_WORD, 32'h3014, 1'b1);
      #1;
      chk("full_stall", 32'(bus.stall), 32'd1);
      tick();
      chk("full_hold_count", 32'(bus.count), 32'd4);
      chk("full_hold_stall", 32'(bus.stall), 32'd1);
      bus.ld_valid = 1'b0;
      #1;
      chk("full_drain_stall", 32'(bus.stall), 32'd0);
      check_drain("d0");
      tick();
      idle_inputs();
      #1;
      chk("full_push_count", 32'(bus.count), 32'd4);
      check_drain("d1");
      tick();
      check_drain("d2");
      tick();
      check_drain("d3");
      tick();
      check_drain("d4");
      tick();
      chk("fill_done_count", 32'(bus.count), 32'd0);

      // Load hazard on a pending word store.
      drive_st(32'h20, 32'hDEADBEEF, WIDTH_WORD, 32'h3020, 1'b1);
      tick();
      idle_inputs();
      drive_ld(32'h20, WIDTH_WORD);
      #1;
      chk("haz_stall", 32'(bus.stall), 32'd1);
      check_drain("haz");
      tick();
      chk("haz_clear_stall", 32'(bus.stall), 32'd0);
      chk("haz_ld_we",       32'(bus.dm_we), 32'd0);
      chk("haz_ld_addr",     bus.dm_addr,    32'h20);
      idle_inputs();

      // Sub-word: byte store at 0x23 conflicts with 0x21, not with 0x24.
      drive_st(32'h23, 32'h0000005A, WIDTH_BYTE, 32'h3024, 1'b1);
      tick();
      idle_inputs();
      drive_ld(32'h24, WIDTH_BYTE);
      #1;
      chk("sub_nohaz_stall", 32'(bus.stall), 32'd0);
      chk("sub_nohaz_addr",  bus.dm_addr,    32'h24);
      chk("sub_nohaz_count", 32'(bus.count), 32'd1);
      drive_ld(32'h21, WIDTH_BYTE);
      #1;
      chk("sub_haz_stall", 32'(bus.stall), 32'd1);
      check_drain("sub");
      tick();
      chk("sub_clear_stall", 32'(bus.stall),    32'd0);
      chk("sub_ld_width",    32'(bus.dm_width), 32'd2);
      chk("sub_ld_addr",     bus.dm_addr,       32'h21);
      idle_inputs();

      // Illegal width: dropped, no stall, no entry.
      drive_st(32'h30, 32'hCAFEF00D, WIDTH_ILLEGAL, 32'h3028, 1'b0);
      #1;
      chk("ill_stall", 32'(bus.stall), 32'd0);
      tick();
      idle_inputs();
      #1;
      chk("ill_count", 32'(bus.count), 32'd0);
      chk("ill_we",    32'(bus.dm_we), 32'd0);

      // Reset with three entries pending discards them.
      drive_ld(32'h200, WIDTH_WORD);
      drive_st(32'h50, 32'h1, WIDTH_WORD, 32'h3030, 1'b0);
      tick();
      drive_st(32'h54, 32'h2, WIDTH_WORD, 32'h3034, 1'b0);
      tick();
      drive_st(32'h58, 32'h3, WIDTH_WORD, 32'h3038, 1'b0);
      tick();
      idle_inputs();
      chk("pre_rst_count", 32'(bus.count), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_count", 32'(bus.count), 32'd0);
      chk("mid_rst_we",    32'(bus.dm_we), 32'd0);
      chk("mid_rst_stall", 32'(bus.stall), 32'd0);
      chk("mid_rst_empty", 32'(bus.empty), 32'd1);
      tick();
      chk("post_rst_we", 32'(bus.dm_we), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
